// File: rtl/network_sequencer_pkg.sv
// Shared definitions for the network run sequencer: mode encodings, FSM states, LFSR constants.
package network_sequencer_pkg;

  typedef logic [2:0] seqStateT;

  localparam logic MODE_TEST  = 1'b0;
  localparam logic MODE_TRAIN = 1'b1;

  localparam seqStateT ST_IDLE     = 3'd0;
  localparam seqStateT ST_ISSUE    = 3'd1;
  localparam seqStateT ST_WAIT_FWD = 3'd2;
  localparam seqStateT ST_WAIT_BWD = 3'd3;
  localparam seqStateT ST_NEXT     = 3'd4;
  localparam seqStateT ST_DONE     = 3'd5;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  // Taps 8,6,5,4 expressed as bit positions 7,5,4,3.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [7:0] lfsrStep(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/network_sequencer_seq_counter.sv
// Up-counter with synchronous clear, enable and a terminal-count flag against a runtime limit.
module seq_counter #(
  parameter int W    = 4,
  parameter bit WRAP = 1'b1
) (
  input  logic         clk,
  input  logic         rstN,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] last,
  output logic [W-1:0] count,
  output logic         tc
);

  assign tc = (count == last);

  // Without WRAP the counter keeps going past last so it can report the final total.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= (WRAP && tc) ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/network_sequencer.sv
// Run-level controller: issues sample indices, waits for forward/backward tokens, counts epochs.
// Build option SEQ_SHUFFLE_EN scrambles the issued index with an LFSR mask that changes per epoch.
module network_sequencer
  import network_sequencer_pkg::*;
#(
  parameter  int NS = 16,
  parameter  int NE = 4,
  localparam int WS = $clog2(NS),
  localparam int WE = $clog2(NE + 1)
) (
  input  logic          iCLK,
  input  logic          iRST,
  input  logic          iStart,
  input  logic          iMode,
  output logic          oMode,
  output logic          oBusy,
  output logic          oDone,
  output logic          oValid_BM_Sample,
  input  logic          iReady_BM_Sample,
  output logic [WS-1:0] oData_BM_Sample,
  input  logic          iValid_AM_Result,
  output logic          oReady_AM_Result,
  input  logic          iValid_AM_Grad,
  output logic          oReady_AM_Grad,
  output logic          oUpdate,
  output logic [WE-1:0] oEpoch
);

  if (NS < 2) begin : gBadNs
    $error("network_sequencer: NS must be at least 2");
  end

  seqStateT stateReg;
  seqStateT stateNext;
  logic     modeReg;
  logic     updateReg;

  logic [WS-1:0] sample;
  logic          sampleTc;
  logic [WE-1:0] epoch;
  logic [WE-1:0] epochLast;
  logic          epochTc;

  logic startAccept;
  logic epochAdvance;

  assign startAccept  = (stateReg == ST_IDLE) && iStart;
  assign epochAdvance = (stateReg == ST_NEXT) && sampleTc;
  assign epochLast    = (modeReg == MODE_TRAIN) ? WE'(NE - 1) : '0;

  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      ST_IDLE:     if (iStart) stateNext = ST_ISSUE;
      ST_ISSUE:    if (iReady_BM_Sample) stateNext = ST_WAIT_FWD;
      ST_WAIT_FWD: if (iValid_AM_Result)
                     stateNext = (modeReg == MODE_TRAIN) ? ST_WAIT_BWD : ST_NEXT;
      ST_WAIT_BWD: if (iValid_AM_Grad) stateNext = ST_NEXT;
      ST_NEXT:     stateNext = (sampleTc && epochTc) ? ST_DONE : ST_ISSUE;
      ST_DONE:     stateNext = ST_IDLE;
      default:     stateNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      stateReg  <= ST_IDLE;
      modeReg   <= MODE_TEST;
      updateReg <= 1'b0;
    end else begin
      stateReg  <= stateNext;
      updateReg <= (stateReg == ST_WAIT_BWD) && iValid_AM_Grad;
      if (startAccept) modeReg <= iMode;
    end
  end

  seq_counter #(.W(WS), .WRAP(1'b1)) uSampleCnt (
    .clk   (iCLK),
    .rstN  (iRST),
    .clr   (startAccept),
    .en    (stateReg == ST_NEXT),
    .last  (WS'(NS - 1)),
    .count (sample),
    .tc    (sampleTc)
  );

  // Epoch count must land on the full total when the run finishes, so it never wraps.
  seq_counter #(.W(WE), .WRAP(1'b0)) uEpochCnt (
    .clk   (iCLK),
    .rstN  (iRST),
    .clr   (startAccept),
    .en    (epochAdvance),
    .last  (epochLast),
    .count (epoch),
    .tc    (epochTc)
  );

`ifdef SEQ_SHUFFLE_EN
  if ((NS & (NS - 1)) != 0 || NS > 256) begin : gBadShuffleNs
    $error("network_sequencer: shuffling needs NS to be a power of two no larger than 256");
  end

  logic [7:0] lfsrReg;

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      lfsrReg <= LFSR_SEED;
    end else if (startAccept) begin
      lfsrReg <= LFSR_SEED;
    end else if (epochAdvance) begin
      lfsrReg <= lfsrStep(lfsrReg);
    end
  end

  // XOR with a fixed mask is a bijection, so each epoch still visits every index once.
  assign oData_BM_Sample = (stateReg == ST_ISSUE) ? (sample ^ lfsrReg[WS-1:0]) : '0;
`else
  assign oData_BM_Sample = (stateReg == ST_ISSUE) ? sample : '0;
`endif

  assign oMode            = modeReg;
  assign oBusy            = (stateReg != ST_IDLE);
  assign oDone            = (stateReg == ST_DONE);
  assign oValid_BM_Sample = (stateReg == ST_ISSUE);
  assign oReady_AM_Result = (stateReg == ST_WAIT_FWD);
  assign oReady_AM_Grad   = (stateReg == ST_WAIT_BWD);
  assign oUpdate          = updateReg;
  assign oEpoch           = epoch;

endmodule

// File: tb/tb_network_sequencer.sv
// Scoreboard bench for network_sequencer: runs TEST/TRAIN sequences with back-pressure, early tokens and abort.
module tb_network_sequencer;
  import network_sequencer_pkg::*;

  localparam int NS = 4;
  localparam int NE = 2;
  localparam int WS = $clog2(NS);
  localparam int WE = $clog2(NE + 1);

  logic          iCLK;
  logic          iRST;
  logic          iStart;
  logic          iMode;
  logic          oMode;
  logic          oBusy;
  logic          oDone;
  logic          oValid;
  logic          iReady;
  logic [WS-1:0] oData;
  logic          iValid_AM_Result;
  logic          oReady_AM_Result;
  logic          iValid_AM_Grad;
  logic          oReady_AM_Grad;
  logic          oUpdate;
  logic [WE-1:0] oEpoch;

  network_sequencer #(.NS(NS), .NE(NE)) dut (
    .iCLK             (iCLK),
    .iRST             (iRST),
    .iStart           (iStart),
    .iMode            (iMode),
    .oMode            (oMode),
    .oBusy            (oBusy),
    .oDone            (oDone),
    .oValid_BM_Sample (oValid),
    .iReady_BM_Sample (iReady),
    .oData_BM_Sample  (oData),
    .iValid_AM_Result (iValid_AM_Result),
    .oReady_AM_Result (oReady_AM_Result),
    .iValid_AM_Grad   (iValid_AM_Grad),
    .oReady_AM_Grad   (oReady_AM_Grad),
    .oUpdate          (oUpdate),
    .oEpoch           (oEpoch)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  int nChecks = 0;
  int nErrors = 0;
  int expQ[$];

  task automatic cyc();
    @(posedge iCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected issue order for a whole run, pushed before the run starts.
  task automatic loadExpected(input logic mode);
    int nEp;
`ifdef SEQ_SHUFFLE_EN
    logic [7:0] m;
    m = 8'hA5;
`endif
    nEp = (mode == MODE_TRAIN) ? NE : 1;
    expQ.delete();
    for (int e = 0; e < nEp; e++) begin
      for (int s = 0; s < NS; s++) begin
`ifdef SEQ_SHUFFLE_EN
        expQ.push_back(s ^ int'(m[WS-1:0]));
`else
        expQ.push_back(s);
`endif
      end
`ifdef SEQ_SHUFFLE_EN
      m = {m[6:0], m[7] ^ m[5] ^ m[4] ^ m[3]};
`endif
    end
  endtask

  task automatic runSeq(input logic mode, input int readyDelay, input int resultDelay,
                        input int expCycles);
    int nHs, nUpd, nDone, hold, rhold, doneCyc, modeBad, nEp;
    bit expUpd, expValid;
    nHs = 0; nUpd = 0; nDone = 0; hold = 0; rhold = 0; doneCyc = -1; modeBad = 0;
    expUpd = 1'b0; expValid = 1'b0;
    nEp = (mode == MODE_TRAIN) ? NE : 1;
    loadExpected(mode);
    iMode = mode;
    iStart = 1'b1;
    iReady = (readyDelay == 0);
    iValid_AM_Result = (resultDelay == 0);
    iValid_AM_Grad = 1'b1;
    cyc();
    chk("firstValid", oValid, 1);
    iMode = ~mode;
    for (int c = 0; c < 2000 && nDone == 0; c++) begin
      if (oMode !== mode) modeBad++;
      chk("update", oUpdate, expUpd);
      if (expValid) begin
        chk("validHold", oValid, 1);
        expValid = 1'b0;
      end
      if (oValid) begin
        chk("issueData", oData, (expQ.size() > 0) ? expQ[0] : -1);
        iReady = (hold >= readyDelay);
        if (iReady) begin
          if (expQ.size() > 0) void'(expQ.pop_front());
          nHs++;
          hold = 0;
        end else begin
          hold++;
          expValid = 1'b1;
        end
      end else begin
        iReady = (readyDelay == 0);
      end
      if (oReady_AM_Result) begin
        chk("gradBlocked", oReady_AM_Grad, 0);
        iValid_AM_Result = (rhold >= resultDelay);
        if (iValid_AM_Result) rhold = 0;
        else rhold++;
      end else begin
        iValid_AM_Result = (resultDelay == 0);
      end
      expUpd = oReady_AM_Grad && iValid_AM_Grad;
      if (oUpdate) nUpd++;
      if (oDone) begin
        nDone++;
        doneCyc = c;
        chk("epochAtDone", oEpoch, nEp);
        chk("busyAtDone", oBusy, 1);
        iStart = 1'b0;
      end
      cyc();
    end
    iStart = 1'b0;
    chk("doneSeen", nDone, 1);
    chk("idleAfterDone", oBusy, 0);
    chk("donePulse", oDone, 0);
    chk("handshakes", nHs, NS * nEp);
    chk("updates", nUpd, (mode == MODE_TRAIN) ? NS * NE : 0);
    chk("queueEmpty", expQ.size(), 0);
    chk("modeStable", modeBad, 0);
    if (expCycles >= 0) chk("runCycles", doneCyc, expCycles);
    $display("run mode=%0d readyDelay=%0d resultDelay=%0d handshakes=%0d updates=%0d doneAt=%0d",
             mode, readyDelay, resultDelay, nHs, nUpd, doneCyc);
  endtask

  task automatic checkResetOutputs(input string tag);
    chk({tag, "_busy"}, oBusy, 0);
    chk({tag, "_done"}, oDone, 0);
    chk({tag, "_valid"}, oValid, 0);
    chk({tag, "_data"}, oData, 0);
    chk({tag, "_rdyRes"}, oReady_AM_Result, 0);
    chk({tag, "_rdyGrad"}, oReady_AM_Grad, 0);
    chk({tag, "_update"}, oUpdate, 0);
    chk({tag, "_mode"}, oMode, MODE_TEST);
    chk({tag, "_epoch"}, oEpoch, 0);
  endtask

  initial begin
    int acc;
    bit reached;
    iRST = 1'b0; iStart = 1'b0; iMode = MODE_TEST; iReady = 1'b0;
    iValid_AM_Result = 1'b0; iValid_AM_Grad = 1'b0;
    #1;
    checkResetOutputs("reset");
    cyc();
    cyc();
    iRST = 1'b1;
    cyc();
    checkResetOutputs("postReset");

    runSeq(MODE_TEST, 0, 0, 3 * NS);
    runSeq(MODE_TRAIN, 0, 0, 4 * NS * NE);
    runSeq(MODE_TRAIN, 5, 0, -1);
    runSeq(MODE_TRAIN, 0, 3, -1);

    // Abort while waiting for the backward token of sample 2.
    iMode = MODE_TRAIN; iStart = 1'b1; iReady = 1'b1;
    iValid_AM_Result = 1'b1; iValid_AM_Grad = 1'b0;
    cyc();
    iStart = 1'b0;
    acc = 0;
    reached = 1'b0;
    for (int c = 0; c < 200 && !reached; c++) begin
      iValid_AM_Grad = (acc < 2);
      if (oReady_AM_Grad) begin
        if (acc == 2) reached = 1'b1;
        else acc++;
      end
      if (!reached) cyc();
    end
    chk("abortReached", reached, 1);
    chk("abortModeTrain", oMode, MODE_TRAIN);
    iRST = 1'b0;
    #1;
    checkResetOutputs("abort");
    cyc();
    chk("abortNoDone", oDone, 0);
    iRST = 1'b1;
    iValid_AM_Grad = 1'b0;
    cyc();
    $display("abort at sample 2 applied");
    runSeq(MODE_TRAIN, 0, 0, 4 * NS * NE);

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
